dcm_lock_sequencer: RTL and testbench
=====================================

# dcm_lock_sequencer

Sequences the TURF clock-multiplier DCM (125 MHz → 250 MHz) from the free-running 33 MHz domain. It drives the DCM reset, waits for lock with a timeout and bounded retries, and requires lock to be held for a settle interval before declaring the 250 MHz clocks good. It then watches for loss of lock or a stopped input clock and re-sequences automatically. It sits between the infrastructure block (`dcm_reset_i`, `dcm_status_o`) and the control registers.

## Interface
Parameters:
- `RESET_CYCLES`, 16: width of the DCM reset pulse in CLK33 cycles; must be ≥ 3.
- `LOCK_TIMEOUT`, 65535: cycles to wait in WAIT_LOCK before a retry.
- `SETTLE_CYCLES`, 1024: cycles lock must be held continuously before `clk_ok_o` asserts.
- `MAX_RETRIES`, 7: consecutive failed attempts before FAIL; must be ≥ 1.

Ports (clock and reset first):
- `CLK33` in 1: controller clock, 33 MHz, independent of the DCM being controlled.
- `rst_i` in 1: reset, asynchronous, active-high.
- `dcm_status_i` in 3: bit2 = LOCKED, bit1 = CLKIN stopped, bit0 = PS overflow (ignored). Asynchronous to CLK33.
- `force_reset_i` in 1: single-cycle request to restart sequencing.
- `dcm_reset_o` out 1: DCM RST.
- `clk_ok_o` out 1: CLK250/CLK250B are usable.
- `fail_o` out 1: retries exhausted.
- `state_o` out 3: current state encoding.
- `retry_count_o` out 4: consecutive failed attempts.
- `relock_count_o` out 8: losses of lock from RUN, saturating.

## Operation
- Status bits 2 and 1 pass through a 2-flop synchronizer giving `locked_s` and `stopped_s`. `good_s` = `locked_s` & ~`stopped_s`.
- States and encodings: RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3, FAIL=4. A single timer is cleared on every state entry.
- **RESET:** `dcm_reset_o`=1. After RESET_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK:**
  - If `good_s`, go to SETTLE.
  - Else, when the timer reaches LOCK_TIMEOUT, increment `retry_count`. If the new value equals MAX_RETRIES go to FAIL, otherwise go to RESET.
- **SETTLE:**
  - If ~`good_s`, increment `retry_count` and go to RESET, or to FAIL if the new value equals MAX_RETRIES.
  - If `good_s` holds for SETTLE_CYCLES cycles, go to RUN and clear `retry_count`.
- **RUN:** `clk_ok_o`=1. If ~`good_s`, increment `relock_count` (saturating at 255) and go to RESET. This does not count as a retry.
- **FAIL:** `fail_o`=1 and `dcm_reset_o`=0. Held until `force_reset_i`.
- **`force_reset_i`:** highest priority in every state.
  - Go to RESET and clear the timer.
  - Clear `retry_count`.
  - Do not increment `relock_count`.
  - In RESET, the reset pulse restarts at full length.
- All outputs are registered and decoded from the registered state. `state_o` is the state register.

## Timing
- Reset values while `rst_i`=1:
  - state=RESET, `dcm_reset_o`=1.
  - `clk_ok_o`=0, `fail_o`=0.
  - `retry_count_o`=0, `relock_count_o`=0.
  - Synchronizer flops=0.
- After `rst_i` falls, `dcm_reset_o` stays 1 for exactly RESET_CYCLES rising edges, then drops.
- Raw-input latency: a change on `dcm_status_i` reaches `good_s` after 2 edges. The FSM acts on the 3rd edge.
- Loss of lock in RUN: `clk_ok_o` falls and `dcm_reset_o` rises on the 3rd edge after the raw LOCKED drop.
- Entry to SETTLE at edge n gives `clk_ok_o`=1 from edge n+SETTLE_CYCLES. A glitch of ≥1 synchronized cycle restarts the sequence.
- WAIT_LOCK entered at edge n times out at edge n+LOCK_TIMEOUT.
- A lock and a timeout in the same cycle: lock wins.
- `force_reset_i` together with any other event: `force_reset_i` wins. The state on the next edge is RESET.
- `rst_i` asserted mid-sequence: all outputs return to reset values immediately (asynchronously).
- Counter widths: timer is wide enough for max(RESET_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES). `retry_count` is 4 bits, so MAX_RETRIES ≤ 15.

## Test plan
Parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, SETTLE_CYCLES=8, MAX_RETRIES=2.
- **Power-up:** release `rst_i`; raise LOCKED 10 cycles later → `dcm_reset_o` high for exactly 4 edges. `clk_ok_o` rises 2+1+8 edges after LOCKED rises. `state_o` steps 0→1→2→3.
- **Timeout/fail:** never assert LOCKED → two RESET/WAIT_LOCK cycles with `retry_count_o` going 1 then 2. Then `state_o`=4, `fail_o`=1 and `dcm_reset_o`=0 held indefinitely. A `force_reset_i` pulse gives `state_o`=0, `retry_count_o`=0 and a 4-cycle reset pulse.
- **Settle glitch:** in SETTLE, drop LOCKED for 1 cycle → RESET with `retry_count_o`=1. Relock and hold → RUN with `retry_count_o`=0.
- **Loss in RUN:** drop LOCKED → `clk_ok_o` low and `dcm_reset_o` high 3 edges later, with `relock_count_o`=1. Repeat 300 times → `relock_count_o` saturates at 255.
- **Stopped input:** in RUN, assert bit1 with LOCKED still high → same response as loss of lock.
- **Priority and reset:**
  - `force_reset_i` on the same edge as the SETTLE completion → RESET, not RUN.
  - `rst_i` pulse in RUN → immediate `clk_ok_o`=0, `dcm_reset_o`=1 and counters at 0.

Source files
------------

// File: rtl/dcm_lock_sequencer_if.sv
// Status and control bundle between the DCM lock sequencer and its surroundings.
// The slave side is the sequencer; the master side is the infrastructure/register side.
`timescale 1ns/1ps
interface dcm_lock_sequencer_if;
    logic [2:0] dcm_status_i;
    logic       force_reset_i;
    logic       dcm_reset_o;
    logic       clk_ok_o;
    logic       fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_count_o;
    logic [7:0] relock_count_o;

    modport slave (
        input  dcm_status_i,
        input  force_reset_i,
        output dcm_reset_o,
        output clk_ok_o,
        output fail_o,
        output state_o,
        output retry_count_o,
        output relock_count_o
    );

    modport master (
        output dcm_status_i,
        output force_reset_i,
        input  dcm_reset_o,
        input  clk_ok_o,
        input  fail_o,
        input  state_o,
        input  retry_count_o,
        input  relock_count_o
    );
endinterface

// File: rtl/dcm_lock_sequencer.sv
// Drives the 125->250 MHz DCM reset from the 33 MHz domain, waits for a stable lock
// with timeout and bounded retries, and re-sequences on loss of lock or stopped input.
`timescale 1ns/1ps
module dcm_lock_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7
) (
    input  logic                  CLK33,
    input  logic                  rst_i,
    dcm_lock_sequencer_if.slave   bus
);

    localparam int MAX_AB  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_T   = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int TIMER_W = (MAX_T < 1) ? 1 : $clog2(MAX_T + 1);

    // Terminal counts sit one below the cycle count: the timer reads k-1 on the k-th edge after entry.
    localparam logic [TIMER_W-1:0] RESET_LAST  = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [1:0]         status_p0;
    logic [1:0]         status_p1;
    logic               locked_s;
    logic               stopped_s;
    logic               good_s;
    logic               unused_ps_overflow;

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [3:0]         retry_q;
    logic [3:0]         retry_nxt;
    logic [3:0]         retry_inc;
    logic [7:0]         relock_q;
    logic [7:0]         relock_nxt;
    logic               dcm_reset_q;
    logic               clk_ok_q;
    logic               fail_q;

    assign unused_ps_overflow = bus.dcm_status_i[0];

    // Stage p0/p1: two-flop synchronizer for LOCKED and CLKIN-stopped
    always_ff @(posedge CLK33 or posedge rst_i) begin
        if (rst_i) begin
            status_p0 <= 2'b00;
            status_p1 <= 2'b00;
        end else begin
            status_p0 <= bus.dcm_status_i[2:1];
            status_p1 <= status_p0;
        end
    end

    assign locked_s  = status_p1[1];
    assign stopped_s = status_p1[0];
    assign good_s    = locked_s & ~stopped_s;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer + 1'b1;
        retry_nxt  = retry_q;
        relock_nxt = relock_q;
        retry_inc  = retry_q + 4'd1;

        case (state)
            ST_RESET: begin
                if (timer == RESET_LAST)
                    state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (good_s) begin
                    state_nxt = ST_SETTLE;
                end else if (timer == LOCK_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                end
            end
            ST_SETTLE: begin
                if (!good_s) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                end else if (timer == SETTLE_LAST) begin
                    retry_nxt = 4'd0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                timer_nxt = timer;
                if (!good_s) begin
                    relock_nxt = sat_inc8(relock_q);
                    state_nxt  = ST_RESET;
                end
            end
            ST_FAIL: begin
                timer_nxt = timer;
            end
            default: begin
                state_nxt = ST_RESET;
            end
        endcase

        if (state_nxt != state)
            timer_nxt = '0;

        // A restart request overrides every transition above, including the relock count.
        if (bus.force_reset_i) begin
            state_nxt  = ST_RESET;
            timer_nxt  = '0;
            retry_nxt  = 4'd0;
            relock_nxt = relock_q;
        end
    end

    // Stage p2: state register with outputs decoded from the next state
    always_ff @(posedge CLK33 or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_RESET;
            timer       <= '0;
            retry_q     <= 4'd0;
            relock_q    <= 8'd0;
            dcm_reset_q <= 1'b1;
            clk_ok_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            retry_q     <= retry_nxt;
            relock_q    <= relock_nxt;
            dcm_reset_q <= (state_nxt == ST_RESET);
            clk_ok_q    <= (state_nxt == ST_RUN);
            fail_q      <= (state_nxt == ST_FAIL);
        end
    end

    assign bus.dcm_reset_o    = dcm_reset_q;
    assign bus.clk_ok_o       = clk_ok_q;
    assign bus.fail_o         = fail_q;
    assign bus.state_o        = state;
    assign bus.retry_count_o  = retry_q;
    assign bus.relock_count_o = relock_q;

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
// Directed bench for dcm_lock_sequencer with small timing parameters.
`timescale 1ns/1ps
module tb_dcm_lock_sequencer;
    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcm_lock_sequencer_if bus();

    dcm_lock_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .SETTLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .CLK33(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;

    // {state, dcm_reset, clk_ok, fail, retry_count}
    logic [9:0] obs;
    assign obs = {bus.state_o, bus.dcm_reset_o, bus.clk_ok_o, bus.fail_o, bus.retry_count_o};

    function automatic logic [9:0] pk(input logic [2:0] st, input logic rs, input logic ok,
                                      input logic fl, input logic [3:0] rt);
        return {st, rs, ok, fl, rt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dcm_status_i  = 3'b000;
        bus.force_reset_i = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic reach_run();
        do_reset();
        bus.dcm_status_i = 3'b100;
        ticks(13);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dcm_status_i  = 3'b100;
        bus.force_reset_i = 1'b0;
        ticks(3);
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL reset_outputs: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        checks++;
        if (bus.relock_count_o !== 8'd0)
            $display("FAIL reset_relock: got %0d expected 0", bus.relock_count_o);
        else passed++;
    endtask

    task automatic test_power_up();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (obs !== pk((k < 4) ? 3'd0 : 3'd1, (k < 4), 1'b0, 1'b0, 4'd0))
                $display("FAIL pu_reset_edge%0d: got %b expected %b", k, obs,
                         pk((k < 4) ? 3'd0 : 3'd1, (k < 4), 1'b0, 1'b0, 4'd0));
            else passed++;
        end
        ticks(6);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pu_wait: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        bus.dcm_status_i = 3'b100;
        ticks(2);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pu_sync_delay: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pu_settle_entry: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        ticks(7);
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pu_settle_last: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0))
            $display("FAIL pu_run: got %b expected %b", obs, pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0));
        else passed++;
    endtask

    task automatic test_timeout_fail();
        do_reset();
        ticks(23);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL to_before1: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1))
            $display("FAIL to_retry1: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1));
        else passed++;
        ticks(4);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1))
            $display("FAIL to_wait2: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1));
        else passed++;
        ticks(19);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1))
            $display("FAIL to_before2: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd4, 1'b0, 1'b0, 1'b1, 4'd2))
            $display("FAIL to_fail: got %b expected %b", obs, pk(3'd4, 1'b0, 1'b0, 1'b1, 4'd2));
        else passed++;
        ticks(30);
        checks++;
        if (obs !== pk(3'd4, 1'b0, 1'b0, 1'b1, 4'd2))
            $display("FAIL to_fail_held: got %b expected %b", obs, pk(3'd4, 1'b0, 1'b0, 1'b1, 4'd2));
        else passed++;
        bus.force_reset_i = 1'b1;
        tick();
        bus.force_reset_i = 1'b0;
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL to_force: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        ticks(3);
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL to_force_pulse: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL to_force_end: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
    endtask

    task automatic test_settle_glitch();
        do_reset();
        bus.dcm_status_i = 3'b100;
        ticks(5);
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL sg_settle: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        bus.dcm_status_i = 3'b000;
        tick();
        bus.dcm_status_i = 3'b100;
        tick();
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL sg_pre_glitch: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1))
            $display("FAIL sg_glitch_reset: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd1));
        else passed++;
        ticks(4);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1))
            $display("FAIL sg_wait: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd1));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1))
            $display("FAIL sg_resettle: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1));
        else passed++;
        ticks(7);
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1))
            $display("FAIL sg_resettle_last: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd1));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0))
            $display("FAIL sg_run: got %b expected %b", obs, pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0));
        else passed++;
    endtask

    task automatic test_loss_in_run();
        int w;
        reach_run();
        checks++;
        if (obs !== pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0))
            $display("FAIL lr_start: got %b expected %b", obs, pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0));
        else passed++;
        for (int i = 0; i < 300; i++) begin
            bus.dcm_status_i = 3'b000;
            ticks(2);
            if (i == 0) begin
                checks++;
                if (obs !== pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0))
                    $display("FAIL lr_edge2: got %b expected %b", obs, pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0));
                else passed++;
            end
            tick();
            checks++;
            if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
                $display("FAIL lr_edge3_iter%0d: got %b expected %b", i, obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
            else passed++;
            checks++;
            if (bus.relock_count_o !== ((i + 1 > 255) ? 8'd255 : 8'(i + 1)))
                $display("FAIL lr_relock_iter%0d: got %0d expected %0d", i, bus.relock_count_o,
                         (i + 1 > 255) ? 255 : i + 1);
            else passed++;
            bus.dcm_status_i = 3'b100;
            w = 0;
            while (bus.state_o !== 3'd3 && w < 40) begin
                tick();
                w++;
            end
            checks++;
            if (bus.state_o !== 3'd3)
                $display("FAIL lr_relock_timeout_iter%0d: got state %0d expected 3", i, bus.state_o);
            else passed++;
        end
    endtask

    task automatic test_stopped();
        reach_run();
        bus.dcm_status_i = 3'b110;
        ticks(2);
        checks++;
        if (obs !== pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0))
            $display("FAIL st_edge2: got %b expected %b", obs, pk(3'd3, 1'b0, 1'b1, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL st_edge3: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        checks++;
        if (bus.relock_count_o !== 8'd1)
            $display("FAIL st_relock: got %0d expected 1", bus.relock_count_o);
        else passed++;
    endtask

    task automatic test_priority();
        int w;
        // restart request on the SETTLE completion edge
        do_reset();
        bus.dcm_status_i = 3'b100;
        ticks(12);
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_settle_last: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        bus.force_reset_i = 1'b1;
        tick();
        bus.force_reset_i = 1'b0;
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_force_vs_run: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;

        // restart request inside RESET restarts the pulse at full length
        do_reset();
        ticks(2);
        bus.force_reset_i = 1'b1;
        tick();
        bus.force_reset_i = 1'b0;
        ticks(3);
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_reset_restart: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_reset_restart_end: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;

        // lock arriving on the timeout edge
        do_reset();
        ticks(21);
        bus.dcm_status_i = 3'b100;
        ticks(2);
        checks++;
        if (obs !== pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_tie_before: got %b expected %b", obs, pk(3'd1, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;
        tick();
        checks++;
        if (obs !== pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_tie_lock_wins: got %b expected %b", obs, pk(3'd2, 1'b0, 1'b0, 1'b0, 4'd0));
        else passed++;

        // asynchronous reset in RUN with a nonzero relock count
        reach_run();
        bus.dcm_status_i = 3'b000;
        ticks(3);
        bus.dcm_status_i = 3'b100;
        w = 0;
        while (bus.state_o !== 3'd3 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (bus.state_o !== 3'd3 || bus.relock_count_o !== 8'd1)
            $display("FAIL pr_rerun: got state %0d relock %0d expected state 3 relock 1",
                     bus.state_o, bus.relock_count_o);
        else passed++;
        rst = 1'b1;
        #2;
        checks++;
        if (obs !== pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0))
            $display("FAIL pr_async_rst: got %b expected %b", obs, pk(3'd0, 1'b1, 1'b0, 1'b0, 4'd0));
        else passed++;
        checks++;
        if (bus.relock_count_o !== 8'd0)
            $display("FAIL pr_async_rst_relock: got %0d expected 0", bus.relock_count_o);
        else passed++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_timeout_fail();
        test_settle_glitch();
        test_loss_in_run();
        test_stopped();
        test_priority();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1);
    end

endmodule
